// File: rtl/padctl_usb_tx.sv
// Full-speed USB transmit line driver: SYNC, NRZI data with bit stuffing, EOP.
// Byte stream in over valid/ready; D+/D-/OE out to pad control.
module padctl_usb_tx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       data_last_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  output logic       usb_dp_o,
  output logic       usb_dn_o,
  output logic       usb_oe_o,
  output logic       busy_o,
  output logic       underrun_o
);

  localparam int unsigned DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [7:0] SYNC_PAT = 8'h80;

  typedef enum logic [1:0] {IDLE, SYNC, DATA, EOP} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_q;
  logic [7:0]       shreg_q;
  logic [7:0]       hold_q;
  logic             hold_last_q;
  logic             last_q;
  logic             avail_q;
  logic             level_q;
  logic [2:0]       bit_idx_q;
  logic [2:0]       stuff_cnt_q;
  logic [1:0]       eop_cnt_q;

  logic strobe;
  logic stuff_due;
  logic tx_bit;
  logic nxt_level;

  // A bit slot ends on the last divider count; stuffing overrides the data bit.
  assign strobe    = (div_q == DIV_MAX);
  assign stuff_due = (stuff_cnt_q == 3'd6);
  assign tx_bit    = stuff_due ? 1'b0 : shreg_q[bit_idx_q];
  assign nxt_level = tx_bit ? level_q : ~level_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      div_q        <= '0;
      shreg_q      <= '0;
      hold_q       <= '0;
      hold_last_q  <= 1'b0;
      last_q       <= 1'b0;
      avail_q      <= 1'b0;
      level_q      <= 1'b1;
      bit_idx_q    <= '0;
      stuff_cnt_q  <= '0;
      eop_cnt_q    <= '0;
      data_ready_o <= 1'b0;
      usb_dp_o     <= 1'b1;
      usb_dn_o     <= 1'b0;
      usb_oe_o     <= 1'b0;
      busy_o       <= 1'b0;
      underrun_o   <= 1'b0;
    end else begin
      data_ready_o <= 1'b0;
      underrun_o   <= 1'b0;
      case (state)
        IDLE: begin
          div_q <= '0;
          if (data_valid_i) begin
            // SYNC is sent as a phantom byte; the real first byte waits in hold_q.
            data_ready_o <= 1'b1;
            hold_q       <= data_i;
            hold_last_q  <= data_last_i;
            shreg_q      <= SYNC_PAT;
            last_q       <= 1'b0;
            avail_q      <= 1'b1;
            bit_idx_q    <= 3'd1;
            stuff_cnt_q  <= '0;
            level_q      <= 1'b0;
            usb_dp_o     <= 1'b0;
            usb_dn_o     <= 1'b1;
            usb_oe_o     <= 1'b1;
            busy_o       <= 1'b1;
            state        <= SYNC;
          end
        end

        SYNC, DATA: begin
          div_q <= strobe ? '0 : div_q + DIV_W'(1);
          if (strobe) begin
            if (stuff_due || avail_q) begin
              level_q  <= nxt_level;
              usb_dp_o <= nxt_level;
              usb_dn_o <= ~nxt_level;
            end
            if (stuff_due) begin
              stuff_cnt_q <= '0;
            end else if (avail_q) begin
              stuff_cnt_q <= tx_bit ? stuff_cnt_q + 3'd1 : 3'd0;
              if (bit_idx_q == 3'd7) begin
                // Bit 7 is going out: line up the next byte so bit 0 follows without a gap.
                bit_idx_q <= '0;
                if (state == SYNC) begin
                  shreg_q <= hold_q;
                  last_q  <= hold_last_q;
                  state   <= DATA;
                end else if (last_q) begin
                  avail_q <= 1'b0;
                end else if (data_valid_i) begin
                  shreg_q      <= data_i;
                  last_q       <= data_last_i;
                  data_ready_o <= 1'b1;
                end else begin
                  underrun_o <= 1'b1;
                  avail_q    <= 1'b0;
                end
              end else begin
                bit_idx_q <= bit_idx_q + 3'd1;
              end
            end else begin
              usb_dp_o  <= 1'b0;
              usb_dn_o  <= 1'b0;
              eop_cnt_q <= '0;
              state     <= EOP;
            end
          end
        end

        EOP: begin
          div_q <= strobe ? '0 : div_q + DIV_W'(1);
          if (strobe) begin
            case (eop_cnt_q)
              2'd0: eop_cnt_q <= 2'd1;
              2'd1: begin
                eop_cnt_q <= 2'd2;
                usb_dp_o  <= 1'b1;
                usb_dn_o  <= 1'b0;
              end
              default: begin
                eop_cnt_q   <= '0;
                div_q       <= '0;
                stuff_cnt_q <= '0;
                usb_oe_o    <= 1'b0;
                usb_dp_o    <= 1'b1;
                usb_dn_o    <= 1'b0;
                busy_o      <= 1'b0;
                state       <= IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_padctl_usb_tx.sv
// Directed bench for padctl_usb_tx: line symbols per bit, packet length, handshake pulses.
module tb_padctl_usb_tx;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic       last;
  logic       valid;
  logic       ready;
  logic       dp;
  logic       dn;
  logic       oe;
  logic       busy;
  logic       underrun;

  int errors = 0;
  int checks = 0;

  string line_s = "";
  int    oe_cyc = 0;
  int    rdy_n  = 0;
  int    rdy_at = -1;
  int    und_n  = 0;
  int    und_at = -1;

  padctl_usb_tx #(.CLKS_PER_BIT(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .data_i       (data),
    .data_last_i  (last),
    .data_valid_i (valid),
    .data_ready_o (ready),
    .usb_dp_o     (dp),
    .usb_dn_o     (dn),
    .usb_oe_o     (oe),
    .busy_o       (busy),
    .underrun_o   (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic string sym(input logic p, input logic n);
    if (p === 1'b1 && n === 1'b0) return "J";
    if (p === 1'b0 && n === 1'b1) return "K";
    if (p === 1'b0 && n === 1'b0) return "0";
    return "X";
  endfunction

  // Record one symbol per driven cycle and where the handshake pulses land.
  always @(negedge clk) begin
    int cyc;
    cyc = oe_cyc;
    if (oe === 1'b1) begin
      line_s = {line_s, sym(dp, dn)};
      oe_cyc++;
    end
    if (ready === 1'b1) begin
      rdy_n++;
      rdy_at = cyc;
    end
    if (underrun === 1'b1) begin
      und_n++;
      und_at = cyc;
    end
  end

  function automatic string collapse(input string s);
    string r;
    r = "";
    for (int i = 0; i < s.len(); i += 4) r = {r, s.substr(i, i)};
    return r;
  endfunction

  function automatic int uniform(input string s);
    for (int i = 0; i < s.len(); i++)
      if (s.getc(i) != s.getc(i - (i % 4))) return 0;
    return 1;
  endfunction

  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_str(input string tag, input string got, input string exp);
    checks++;
    assert (got == exp) else begin
      errors++;
      $error("FAIL %s observed=%s expected=%s", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    line_s = "";
    oe_cyc = 0;
    rdy_n  = 0;
    rdy_at = -1;
    und_n  = 0;
    und_at = -1;
  endtask

  // Present a byte with valid and check the first driven cycle is a K with ready.
  task automatic start_pkt(input string tag, input logic [7:0] d, input logic l);
    clear_mon();
    data  = d;
    last  = l;
    valid = 1'b1;
    @(posedge clk); #1;
    check_int({tag, "_start_ready"}, int'(ready), 1);
    check_int({tag, "_start_oe"}, int'(oe), 1);
    check_str({tag, "_start_line"}, sym(dp, dn), "K");
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check_int({tag, "_timeout"}, int'(busy === 1'b1), 0);
  endtask

  task automatic check_pkt(input string tag, input string exp, input int rdy_exp, input int und_exp);
    check_str({tag, "_bits"}, collapse(line_s), exp);
    check_int({tag, "_oe_cycles"}, oe_cyc, exp.len() * 4);
    check_int({tag, "_sym_width"}, uniform(line_s), 1);
    check_int({tag, "_ready_cnt"}, rdy_n, rdy_exp);
    check_int({tag, "_underrun_cnt"}, und_n, und_exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst   = 1'b1;
    data  = 8'h00;
    last  = 1'b0;
    valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_int("rst_oe", int'(oe), 0);
    check_int("rst_dp", int'(dp), 1);
    check_int("rst_dn", int'(dn), 0);
    check_int("rst_ready", int'(ready), 0);
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_underrun", int'(underrun), 0);

    // Reset beats a simultaneous valid.
    valid = 1'b1;
    @(posedge clk); #1;
    check_int("rst_vs_valid_ready", int'(ready), 0);
    check_int("rst_vs_valid_oe", int'(oe), 0);
    valid = 1'b0;
    rst   = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single zero byte.
    start_pkt("b00", 8'h00, 1'b1);
    valid = 1'b0;
    wait_idle("b00");
    check_pkt("b00", "KJKJKJKKJKJKJKJK00J", 1, 0);
    check_int("b00_ready_at", rdy_at, 0);
    check_int("b00_idle_dp", int'(dp), 1);
    check_int("b00_idle_dn", int'(dn), 0);
    repeat (3) @(posedge clk);
    #1;

    // Single 0xFF: stuff bit after six ones (five data ones plus SYNC's last one).
    start_pkt("bff", 8'hFF, 1'b1);
    valid = 1'b0;
    wait_idle("bff");
    check_pkt("bff", "KJKJKJKKKKKKKJJJJ00J", 1, 0);
    repeat (2) @(posedge clk);
    #1;

    // Two bytes, valid held; second ready when bit 7 of the first byte goes out.
    start_pkt("two", 8'h3F, 1'b0);
    data = 8'h01;
    last = 1'b1;
    n = 0;
    while (rdy_n < 2 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    valid = 1'b0;
    check_int("two_ready_timeout", int'(rdy_n < 2), 0);
    check_int("two_ready2_at", rdy_at, 64);
    wait_idle("two");
    check_pkt("two", "KJKJKJKKKKKKKJJKJJKJKJKJK00J", 2, 0);
    repeat (2) @(posedge clk);
    #1;

    // Underrun: non-last byte with no follow-up.
    start_pkt("und", 8'hA5, 1'b0);
    valid = 1'b0;
    wait_idle("und");
    check_pkt("und", "KJKJKJKKKJJKJJKK00J", 1, 1);
    check_int("und_at", und_at, 60);
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of DATA, then a clean restart.
    start_pkt("rmid", 8'h00, 1'b1);
    valid = 1'b0;
    repeat (48) @(posedge clk);
    #1;
    check_int("rmid_pre_busy", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_int("rmid_oe", int'(oe), 0);
    check_int("rmid_dp", int'(dp), 1);
    check_int("rmid_dn", int'(dn), 0);
    check_int("rmid_busy", int'(busy), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    start_pkt("rnew", 8'h00, 1'b1);
    valid = 1'b0;
    wait_idle("rnew");
    check_pkt("rnew", "KJKJKJKKJKJKJKJK00J", 1, 0);
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back 0xFF packets with valid held across EOP.
    start_pkt("bb1", 8'hFF, 1'b1);
    wait_idle("bb1");
    check_int("bb1_gap_oe", int'(oe), 0);
    check_pkt("bb1", "KJKJKJKKKKKKKJJJJ00J", 1, 0);
    clear_mon();
    @(posedge clk); #1;
    check_int("bb2_start_oe", int'(oe), 1);
    check_int("bb2_start_ready", int'(ready), 1);
    check_str("bb2_start_line", sym(dp, dn), "K");
    valid = 1'b0;
    wait_idle("bb2");
    check_pkt("bb2", "KJKJKJKKKKKKKJJJJ00J", 1, 0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
